count_ctrl: RTL and testbench
=============================

# count_ctrl

Sequencing controller for the team's 8-bit ripple-enable T-flip-flop counter. It owns the counter's `enable` and `resetb` inputs and reads back its `Q`. It clears the counter, paces increments from a selectable prescaler, and stops at a programmable limit or wraps there. Status goes back to the switch/LED/HEX top level.

## Interface
- `PW`, 26: prescaler width in bits; must hold `DIV3-1`.
- `DIV1`, 4: tick period in cycles for `rate_sel=01`.
- `DIV2`, 16: tick period in cycles for `rate_sel=10`.
- `DIV3`, 50_000_000: tick period in cycles for `rate_sel=11`.

Ports:
- `clock`  in  1  single system clock; all flops rise-edge.
- `resetb`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a run; sampled in IDLE and DONE.
- `abort`  in  1  return to IDLE; highest priority.
- `pause`  in  1  level; freezes prescaler and suppresses increments in RUN.
- `wrap`  in  1  0 = one-shot, 1 = restart from 0 after reaching `limit`.
- `rate_sel`  in  2  00 = every cycle, 01 = `DIV1`, 10 = `DIV2`, 11 = `DIV3`.
- `limit`  in  8  terminal count.
- `ctr_q`  in  8  counter value read back from the counter.
- `ctr_enable`  out  1  counter enable; counter increments on the same edge.
- `ctr_resetb`  out  1  counter clear, active-low, driven directly from a flop.
- `busy`  out  1  high in CLR or RUN.
- `done`  out  1  high in DONE.
- `tc`  out  1  terminal-count strobe.

## Operation
- States: IDLE, CLR, RUN, DONE. The state register is reset to IDLE.
- Transition priority: `abort` first, then the rules below.
- `abort`=1 in any state: next state is IDLE. `ctr_enable` is 0 that cycle. The counter value is retained.
- IDLE:
  - `start`=1 goes to CLR.
  - Otherwise stays. The counter holds its value.
- CLR:
  - Lasts exactly one cycle, then RUN.
  - Prescaler loads 0.
  - `ctr_resetb` is 0 for exactly this cycle.
- RUN:
  - `tick` = (prescaler >= N-1), where N is selected by `rate_sel`.
  - With `pause`=0, the prescaler goes to 0 if `tick`, else increments by 1. With `pause`=1, the prescaler holds.
  - `ctr_enable` = RUN & `tick` & ~`pause` & (`ctr_q` != `limit`). This is combinational from registered state, the prescaler and inputs.
  - `ctr_q`==`limit` with `wrap`=0 goes to DONE.
  - `ctr_q`==`limit` with `wrap`=1 goes to CLR.
  - `start` is ignored.
- DONE:
  - `done`=1 and the counter holds at `limit`.
  - `start`=1 goes to CLR.
  - Otherwise stays.
- `tc` = RUN & (`ctr_q`==`limit`): a one-cycle strobe on each arrival at the limit.
- Changing `rate_sel` mid-run: the `>=` compare guarantees a tick on the next cycle if the prescaler already exceeds the new N-1. There is no lockup.
- `limit`=0: CLR, then one RUN cycle with `tc`=1 and no enable, then DONE (or CLR again if `wrap`=1).
- `limit` and `wrap` are read live; changing them mid-run takes effect the same cycle.

## Timing
- Reset values:
  - state IDLE, prescaler 0.
  - `ctr_resetb`=0 while `resetb` is low, so the counter clears with the system.
  - `ctr_enable`=0, `busy`=0, `done`=0, `tc`=0.
- First edge after reset release: `ctr_resetb`=1.
- The flop behind `ctr_resetb` has next value ~(next_state==CLR), so `ctr_resetb` is glitch-free.
- Reset asserted mid-run: all state is cleared immediately without waiting for a clock edge. `ctr_resetb` drops asynchronously.
- Latency, `start` to CLR: 1 cycle.
- First RUN cycle: CLR + 1.
- First increment: N cycles after entering RUN, i.e. the cycle in which the prescaler equals N-1.
- Counter reaches `limit` L in RUN: `tc` is high that cycle, and DONE (or CLR) follows on the next edge.
- `rate_sel`=00: one increment per RUN cycle. A one-shot from 0 to L therefore spends L+1 cycles in RUN.
- `pause` in RUN: the cycle with `pause`=1 produces no increment and no prescaler advance. Resumes seamlessly.

## Test plan
- Defaults, `rate_sel`=01, `limit`=3, `wrap`=0, `start` pulsed at cycle 0 -> CLR at 1 with `ctr_resetb`=0, RUN from 2, `ctr_enable` at cycles 5/9/13, `ctr_q`=3 at 14 with `tc`=1, `done`=1 from 15 with `ctr_q` held at 3.
- `rate_sel`=00, `limit`=5, `wrap`=1 -> `ctr_q` sequence 0,1,2,3,4,5, one CLR cycle, then 0 again; `tc` pulses once per lap (every 7 cycles); `done` never asserts.
- `rate_sel`=01 run with `pause`=1 held for cycles 4-7 -> prescaler frozen at 2; first `ctr_enable` moves from cycle 5 to cycle 9.
- `abort` in RUN with `ctr_q`=2 -> IDLE next edge, `ctr_enable`=0 in the abort cycle, `ctr_q` stays 2, `busy`=0. Then `start` -> CLR clears to 0.
- `limit`=0, `wrap`=0 -> exactly one RUN cycle with `tc`=1, zero enables, then DONE. `start` in DONE restarts via CLR.
- `resetb` pulsed low mid-RUN (`ctr_q`=4) -> outputs reach reset values before the next edge; `ctr_resetb`=1 one edge after release; state IDLE.

Source files
------------

// File: rtl/count_ctrl.sv
// count_ctrl: sequencing controller for the 8-bit ripple-enable counter.
// Clears, paces, and stops or wraps the counter at a programmable limit.
module count_ctrl #(
  parameter int PW   = 26,
  parameter int DIV1 = 4,
  parameter int DIV2 = 16,
  parameter int DIV3 = 50_000_000
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       start,
  input  logic       abort,
  input  logic       pause,
  input  logic       wrap,
  input  logic [1:0] rate_sel,
  input  logic [7:0] limit,
  input  logic [7:0] ctr_q,
  output logic       ctr_enable,
  output logic       ctr_resetb,
  output logic       busy,
  output logic       done,
  output logic       tc
);

  typedef enum logic [1:0] {
    IDLE,
    CLR,
    RUN,
    DONE
  } state_t;

  localparam logic [PW-1:0] M1 = PW'(DIV1 - 1);
  localparam logic [PW-1:0] M2 = PW'(DIV2 - 1);
  localparam logic [PW-1:0] M3 = PW'(DIV3 - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          ctr_resetb_q, ctr_resetb_d;
  logic [PW-1:0] n_m1;
  logic          tick;
  logic          at_lim;
  logic          in_run;

  // Terminal prescaler value for the selected rate
  always_comb begin
    n_m1 = '0;
    unique case (rate_sel)
      2'b00: n_m1 = '0;
      2'b01: n_m1 = M1;
      2'b10: n_m1 = M2;
      2'b11: n_m1 = M3;
      default: n_m1 = '0;
    endcase
  end

  assign tick   = (presc_q >= n_m1);
  assign at_lim = (ctr_q == limit);
  assign in_run = (state_q == RUN);

  // Next state, prescaler and counter-clear request
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = CLR;
        end
        CLR: begin
          state_d = RUN;
          presc_d = '0;
        end
        RUN: begin
          if (!pause) presc_d = tick ? '0 : presc_q + PW'(1);
          if (at_lim) state_d = wrap ? CLR : DONE;
        end
        DONE: begin
          if (start) state_d = CLR;
        end
        default: state_d = IDLE;
      endcase
    end
    ctr_resetb_d = (state_d != CLR);
  end

  // State, prescaler and registered counter clear
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      ctr_resetb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      ctr_resetb_q <= ctr_resetb_d;
    end
  end

  assign ctr_enable = in_run & tick & ~pause & ~at_lim & ~abort;
  assign ctr_resetb = ctr_resetb_q;
  assign busy       = (state_q == CLR) | in_run;
  assign done       = (state_q == DONE);
  assign tc         = in_run & at_lim;

endmodule

// File: tb/tb_count_ctrl.sv
// tb_count_ctrl: directed bench for count_ctrl with a behavioural
// model of the 8-bit counter it drives.
module tb_count_ctrl;

  logic       clock = 1'b0;
  logic       resetb;
  logic       start, abort, pause, wrap;
  logic [1:0] rate_sel;
  logic [7:0] limit;
  logic [7:0] ctr_q;
  logic       ctr_enable, ctr_resetb, busy, done, tc;

  int n_tests = 0;
  int n_fail  = 0;

  count_ctrl #(
    .PW(26), .DIV1(4), .DIV2(16), .DIV3(50_000_000)
  ) dut (
    .clock(clock), .resetb(resetb),
    .start(start), .abort(abort),
    .pause(pause), .wrap(wrap),
    .rate_sel(rate_sel), .limit(limit),
    .ctr_q(ctr_q), .ctr_enable(ctr_enable),
    .ctr_resetb(ctr_resetb), .busy(busy),
    .done(done), .tc(tc)
  );

  always #5 clock = ~clock;

  // Counter model: async active-low clear, increment on enable
  always @(posedge clock or negedge ctr_resetb) begin
    if (!ctr_resetb) ctr_q <= 8'd0;
    else if (ctr_enable) ctr_q <= ctr_q + 8'd1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetb = 1'b0;
    start = 0; abort = 0; pause = 0; wrap = 0;
    rate_sel = 2'b01; limit = 8'd3;
    #2;
    chk("rst_ctr_resetb", ctr_resetb, 0);
    chk("rst_en", ctr_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tc", tc, 0);
    #20 resetb = 1'b1;
    nxt();
    chk("rel_ctr_resetb", ctr_resetb, 1);
    chk("rel_q", ctr_q, 0);

    // One-shot, rate 01, limit 3
    nxt(); start = 1; rate_sel = 2'b01; limit = 8'd3; wrap = 0; #1;
    chk("t1_c0_busy", busy, 0);
    for (int c = 1; c <= 16; c++) begin
      nxt(); start = 0; #1;
      chk("t1_en", ctr_enable, (c == 5 || c == 9 || c == 13));
      if (c == 1) begin
        chk("t1_clr_rb", ctr_resetb, 0);
        chk("t1_clr_busy", busy, 1);
      end
      if (c == 2) chk("t1_run_rb", ctr_resetb, 1);
      if (c == 14) begin
        chk("t1_q_lim", ctr_q, 3);
        chk("t1_tc", tc, 1);
      end
      if (c >= 15) begin
        chk("t1_done", done, 1);
        chk("t1_q_hold", ctr_q, 3);
        chk("t1_tc_off", tc, 0);
      end
    end

    // Wrap, rate 00, limit 5: 7-cycle laps
    nxt(); start = 1; rate_sel = 2'b00; limit = 8'd5; wrap = 1; #1;
    for (int c = 1; c <= 21; c++) begin
      nxt(); start = 0; #1;
      chk("t2_done", done, 0);
      if ((c - 1) % 7 == 0) begin
        chk("t2_clr_rb", ctr_resetb, 0);
        chk("t2_clr_q", ctr_q, 0);
      end else begin
        chk("t2_q", ctr_q, (c - 1) % 7 - 1);
        chk("t2_tc", tc, ((c - 1) % 7 == 6));
      end
    end

    // Abort in RUN at ctr_q=2
    nxt(); limit = 8'd200; wrap = 0; #1;
    chk("t3_clr_rb", ctr_resetb, 0);
    nxt(); #1;
    chk("t3_q0", ctr_q, 0);
    chk("t3_en0", ctr_enable, 1);
    nxt(); #1;
    chk("t3_q1", ctr_q, 1);
    nxt(); abort = 1; #1;
    chk("t3_q2", ctr_q, 2);
    chk("t3_abort_en", ctr_enable, 0);
    nxt(); abort = 0; #1;
    chk("t3_busy", busy, 0);
    chk("t3_done", done, 0);
    chk("t3_q_keep", ctr_q, 2);
    nxt(); #1;
    chk("t3_q_idle", ctr_q, 2);
    nxt(); start = 1; #1;
    nxt(); start = 0; #1;
    chk("t3_re_rb", ctr_resetb, 0);
    chk("t3_re_q", ctr_q, 0);
    chk("t3_re_busy", busy, 1);

    // Pause cycles 4-7 at rate 01 (now in CLR = cycle 1)
    rate_sel = 2'b01;
    for (int c = 2; c <= 10; c++) begin
      nxt(); pause = (c >= 4 && c <= 7); #1;
      chk("t4_en", ctr_enable, (c == 9));
      if (c <= 9) chk("t4_q", ctr_q, 0);
    end
    chk("t4_q_after", ctr_q, 1);
    nxt(); abort = 1; #1;
    nxt(); abort = 0; #1;
    chk("t4_idle", busy, 0);

    // limit 0 one-shot, then restart from DONE
    nxt(); start = 1; limit = 8'd0; wrap = 0; #1;
    nxt(); start = 0; #1;
    chk("t5_clr_rb", ctr_resetb, 0);
    nxt(); #1;
    chk("t5_tc", tc, 1);
    chk("t5_en", ctr_enable, 0);
    chk("t5_busy", busy, 1);
    nxt(); #1;
    chk("t5_done", done, 1);
    chk("t5_tc_off", tc, 0);
    chk("t5_q", ctr_q, 0);
    nxt(); start = 1; #1;
    chk("t5_done2", done, 1);
    nxt(); start = 0; #1;
    chk("t5_restart_rb", ctr_resetb, 0);
    chk("t5_restart_busy", busy, 1);

    // Reset mid-RUN at ctr_q=4
    nxt(); limit = 8'd200; rate_sel = 2'b00; #1;
    chk("t6_q0", ctr_q, 0);
    for (int i = 0; i < 4; i++) nxt();
    #1;
    chk("t6_q4", ctr_q, 4);
    #2 resetb = 1'b0;
    #1;
    chk("t6_rb_async", ctr_resetb, 0);
    chk("t6_busy", busy, 0);
    chk("t6_en", ctr_enable, 0);
    chk("t6_tc", tc, 0);
    chk("t6_q_clr", ctr_q, 0);
    #2 resetb = 1'b1;
    nxt();
    chk("t6_rb_rel", ctr_resetb, 1);
    chk("t6_idle", busy, 0);
    chk("t6_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
